// File: rtl/bus_rr_sched_if.sv
// Shared packet-bus signals between the per-device FIFOs and the round-robin scheduler.
// master = scheduler side, slave = device/FIFO side.
interface bus_rr_sched_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         rx_full;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic [drvrs-1:0]         grant;

  modport master (
    input  pndng, D_pop, rx_full,
    output pop, push, D_push, grant
  );

  modport slave (
    output pndng, D_pop, rx_full,
    input  pop, push, D_push, grant
  );
endinterface

// File: rtl/bus_rr_sched.sv
// Round-robin packet bus scheduler: grant a pending source, decode its header, wait for room, move it.
// Optional WAIT timeout (drop after max_wait cycles) enabled by defining BUS_SCHED_TIMEOUT_EN.
module bus_rr_sched #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         max_wait  = 32
) (
  input  logic           clk,
  input  logic           reset,
  bus_rr_sched_if.master bus,
  output logic           busy,
  output logic [15:0]    drop_cnt
);

  localparam int ptr_w = $clog2(drvrs);
  localparam int idx_w = ptr_w + 1;
  localparam logic [drvrs-1:0] lsb_one = {{(drvrs-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, GRANT, WAIT, XFER, DROP} state_t;

  state_t             state_reg, state_next;
  logic [ptr_w-1:0]   src_reg, src_next;
  logic [ptr_w-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [pckg_sz-1:0] pkt_reg, pkt_next;
  logic [drvrs-1:0]   mask_reg, mask_next;
  logic [15:0]        drop_cnt_reg, drop_cnt_next;

  // Per-device view of the FIFO heads
  logic [pckg_sz-1:0] head [drvrs];
  generate
    for (genvar gi = 0; gi < drvrs; gi++) begin : g_head
      assign head[gi] = bus.D_pop[gi*pckg_sz +: pckg_sz];
    end
  endgenerate

  // First pending device at or after rr_ptr, wrapping modulo drvrs
  logic [ptr_w-1:0] rr_sel;
  logic             rr_found;
  logic [idx_w-1:0] rr_idx;

  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < drvrs; k++) begin
      rr_idx = {1'b0, rr_ptr_reg} + idx_w'(k);
      if (rr_idx >= idx_w'(drvrs)) begin
        rr_idx = rr_idx - idx_w'(drvrs);
      end
      if (!rr_found && bus.pndng[rr_idx[ptr_w-1:0]]) begin
        rr_sel   = rr_idx[ptr_w-1:0];
        rr_found = 1'b1;
      end
    end
  end

  // Header decode of the granted source's head packet
  logic [drvrs-1:0]   src_onehot;
  logic [pckg_sz-1:0] cur_pkt;
  logic [7:0]         cur_dest;
  logic [drvrs-1:0]   cur_mask;
  logic               cur_valid;

  assign src_onehot = lsb_one << src_reg;
  assign cur_pkt    = head[src_reg];
  assign cur_dest   = cur_pkt[pckg_sz-1 -: 8];

  always_comb begin
    cur_mask  = '0;
    cur_valid = 1'b0;
    if (cur_dest == broadcast) begin
      cur_mask  = ~src_onehot;
      cur_valid = 1'b1;
    end else if ((cur_dest < 8'(drvrs)) && (cur_dest != 8'(src_reg))) begin
      cur_mask  = lsb_one << cur_dest[ptr_w-1:0];
      cur_valid = 1'b1;
    end
  end

  logic [ptr_w-1:0] src_inc;
  assign src_inc = (src_reg == ptr_w'(drvrs - 1)) ? '0 : src_reg + 1'b1;

`ifdef BUS_SCHED_TIMEOUT_EN
  localparam int wait_w = $clog2(max_wait + 1);
  logic [wait_w-1:0] wait_cnt_reg;
  logic              wait_expired;

  assign wait_expired = (wait_cnt_reg == wait_w'(max_wait - 1));

  // Counts completed WAIT cycles; clears whenever WAIT is left
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg <= '0;
    end else if ((state_reg == WAIT) && (state_next == WAIT)) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end else begin
      wait_cnt_reg <= '0;
    end
  end
`endif

  always_comb begin
    state_next    = state_reg;
    src_next      = src_reg;
    rr_ptr_next   = rr_ptr_reg;
    pkt_next      = pkt_reg;
    mask_next     = mask_reg;
    drop_cnt_next = drop_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (rr_found) begin
          src_next   = rr_sel;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!bus.pndng[src_reg]) begin
          state_next = IDLE;
        end else begin
          pkt_next  = cur_pkt;
          mask_next = cur_mask;
          if (!cur_valid) begin
            state_next = DROP;
          end else if ((cur_mask & bus.rx_full) == '0) begin
            state_next = XFER;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.pndng[src_reg]) begin
          state_next = IDLE;
        end else if ((mask_reg & bus.rx_full) == '0) begin
          state_next = XFER;
        end
`ifdef BUS_SCHED_TIMEOUT_EN
        else if (wait_expired) begin
          state_next = DROP;
        end
`endif
      end
      XFER, DROP: begin
        rr_ptr_next = src_inc;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // DROP lasts one cycle, so this fires once per dropped packet and is visible during DROP
    if ((state_next == DROP) && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_next = drop_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      src_reg      <= '0;
      rr_ptr_reg   <= '0;
      pkt_reg      <= '0;
      mask_reg     <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      src_reg      <= src_next;
      rr_ptr_reg   <= rr_ptr_next;
      pkt_reg      <= pkt_next;
      mask_reg     <= mask_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Outputs depend on registers only
  assign busy       = (state_reg != IDLE);
  assign bus.grant  = busy ? src_onehot : '0;
  assign bus.pop    = ((state_reg == XFER) || (state_reg == DROP)) ? src_onehot : '0;
  assign bus.push   = (state_reg == XFER) ? mask_reg : '0;
  assign bus.D_push = (state_reg == XFER) ? pkt_reg : '0;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Self-checking bench for bus_rr_sched: FIFO emulation, cycle model, per-cycle compare, directed checks.
module tb_bus_rr_sched;
  localparam int N = 4;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic [15:0] drop_cnt;

  bus_rr_sched_if #(.drvrs(N), .pckg_sz(W)) bus ();

  bus_rr_sched #(.drvrs(N), .pckg_sz(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Device TX FIFOs, popped when the DUT pulses pop
  logic [15:0]  fifo_mem [N][8];
  int           fifo_cnt [N];
  logic [N-1:0] last_pop = '0;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      bus.pndng[i]         = (fifo_cnt[i] != 0);
      bus.D_pop[i*W +: W]  = (fifo_cnt[i] != 0) ? fifo_mem[i][0] : 16'h0000;
    end
  endtask

  task automatic enqueue(input int dev, input logic [15:0] pkt);
    fifo_mem[dev][fifo_cnt[dev]] = pkt;
    fifo_cnt[dev]++;
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (last_pop[i] && fifo_cnt[i] > 0) begin
        for (int k = 0; k < 7; k++) fifo_mem[i][k] = fifo_mem[i][k+1];
        fifo_cnt[i]--;
      end
    end
    refresh();
  endtask

  // Model: stage 0 idle, 1 owner chosen, 2 waiting for room, 3 moving, 4 discarding
  int           m_stage = 0;
  int           m_owner = 0;
  int           m_ptr   = 0;
  logic [15:0]  m_pkt   = '0;
  logic [N-1:0] m_mask  = '0;
  logic [15:0]  m_drops = '0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_stage = 0; m_owner = 0; m_ptr = 0;
        m_pkt = '0; m_mask = '0; m_drops = '0;
      end else begin
        case (m_stage)
          0: begin
            for (int k = N - 1; k >= 0; k--) begin
              if (bus.pndng[(m_ptr + k) % N]) begin
                m_owner = (m_ptr + k) % N;
                m_stage = 1;
              end
            end
          end
          1: begin
            if (!bus.pndng[m_owner]) begin
              m_stage = 0;
            end else begin
              int dest;
              m_pkt = bus.D_pop[m_owner*W +: W];
              dest  = int'(m_pkt[15:8]);
              if (dest == 255) begin
                m_mask = '1;
                m_mask[m_owner] = 1'b0;
              end else if (dest < N && dest != m_owner) begin
                m_mask = '0;
                m_mask[dest] = 1'b1;
              end else begin
                m_mask = '0;
                dest = -1;
              end
              if (dest < 0) begin
                m_stage = 4;
                if (m_drops != 16'hFFFF) m_drops = m_drops + 1;
              end else begin
                m_stage = ((m_mask & bus.rx_full) == 0) ? 3 : 2;
              end
            end
          end
          2: begin
            if (!bus.pndng[m_owner]) m_stage = 0;
            else if ((m_mask & bus.rx_full) == 0) m_stage = 3;
          end
          default: begin
            m_ptr   = (m_owner + 1) % N;
            m_stage = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  initial begin
    forever begin
      logic [N-1:0] e_own;
      @(negedge clk);
      e_own = '0;
      if (m_stage != 0) e_own[m_owner] = 1'b1;
      check("grant",  bus.grant, e_own);
      check("pop",    bus.pop, (m_stage == 3 || m_stage == 4) ? e_own : '0);
      check("push",   bus.push, (m_stage == 3) ? m_mask : '0);
      check("D_push", bus.D_push, (m_stage == 3) ? m_pkt : 16'h0);
      check("busy",   busy, m_stage != 0);
      check("drops",  drop_cnt, m_drops);
      if (bus.pop != 0)
        $display("txn t=%0t pop=%b push=%b data=%h drop_cnt=%0d", $time, bus.pop, bus.push, bus.D_push, drop_cnt);
      last_pop = bus.pop;
    end
  end

  task automatic wait_pop(input logic [N-1:0] exp_pop, input int exp_n, input string name);
    int n = 0;
    do begin
      tick();
      @(negedge clk);
      n++;
    end while (bus.pop == 0 && n < 20);
    check({name, "_pop"}, bus.pop, exp_pop);
    check({name, "_lat"}, n, exp_n);
  endtask

  int fair_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [N-1:0] one;
    one = 1;
    for (int i = 0; i < N; i++) fifo_cnt[i] = 0;
    bus.rx_full = '0;
    refresh();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", bus.grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_drops", drop_cnt, 16'h0000);
    @(posedge clk);
    #2 reset = 1'b1;

    // Fairness: everybody pending, dev0 twice
    enqueue(0, 16'h01A0); enqueue(0, 16'h02A1);
    enqueue(1, 16'h02B0); enqueue(2, 16'h03C0); enqueue(3, 16'h00D0);
    for (int j = 0; j < 5; j++) begin
      wait_pop(one << fair_seq[j], (j == 0) ? 2 : 3, "fair");
      check("fair_grant", bus.grant, one << fair_seq[j]);
    end

    // Unicast dev1 -> dev2
    tick();
    enqueue(1, 16'h02AB);
    wait_pop(4'b0010, 2, "uni");
    check("uni_push", bus.push, 4'b0100);
    check("uni_data", bus.D_push, 16'h02AB);
    check("uni_grant", bus.grant, 4'b0010);

    // Broadcast from dev2
    tick();
    enqueue(2, 16'hFF55);
    wait_pop(4'b0100, 2, "bc");
    check("bc_push", bus.push, 4'b1011);
    check("bc_data", bus.D_push, 16'hFF55);

    // Backpressure on dev3
    tick();
    bus.rx_full = 4'b1000;
    enqueue(0, 16'h0312);
    for (int j = 0; j < 11; j++) begin
      tick();
      @(negedge clk);
      check("bp_pop", bus.pop, 4'b0000);
      check("bp_push", bus.push, 4'b0000);
      check("bp_busy", busy, 1'b1);
    end
    bus.rx_full = 4'b0000;
    tick();
    @(negedge clk);
    check("bp_rel_push", bus.push, 4'b1000);
    check("bp_rel_pop", bus.pop, 4'b0001);
    check("bp_rel_data", bus.D_push, 16'h0312);

    // Invalid destination, then self-addressed
    tick();
    enqueue(0, 16'h0712);
    wait_pop(4'b0001, 2, "bad_id");
    check("bad_id_push", bus.push, 4'b0000);
    check("bad_id_drops", drop_cnt, 16'd1);
    tick();
    enqueue(0, 16'h0034);
    wait_pop(4'b0001, 2, "self");
    check("self_data", bus.D_push, 16'h0000);
    check("self_drops", drop_cnt, 16'd2);

    // Source withdraws while waiting: no pop, pointer stays at 1
    tick();
    bus.rx_full = 4'b0100;
    enqueue(3, 16'h0277);
    repeat (4) tick();
    fifo_cnt[3] = 0;
    refresh();
    tick();
    @(negedge clk);
    check("abandon_busy", busy, 1'b0);
    check("abandon_pop", bus.pop, 4'b0000);
    bus.rx_full = 4'b0000;
    enqueue(0, 16'h0211);
    enqueue(3, 16'h0133);
    wait_pop(4'b1000, 2, "ptr_kept");
    wait_pop(4'b0001, 3, "ptr_next");

    // Asynchronous reset while waiting
    tick();
    bus.rx_full = 4'b1000;
    enqueue(0, 16'h0322);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("arst_grant", bus.grant, 4'b0000);
    check("arst_busy", busy, 1'b0);
    check("arst_pop", bus.pop, 4'b0000);
    check("arst_drops", drop_cnt, 16'h0000);
    tick();
    check("arst_kept", fifo_cnt[0], 1);
    reset = 1'b1;
    bus.rx_full = 4'b0000;
    wait_pop(4'b0001, 2, "after_rst");
    check("after_rst_push", bus.push, 4'b1000);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
